// File: rtl/i2s_frame_packer_if.sv
// I2S frame packer bus: sample input side and
// committed-frame output side with status.
interface i2s_frame_packer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 2,
  parameter int CH_W       = 1,
  parameter int CNT_W      = 8
);
  logic [DATA_WIDTH-1:0]        in_data;
  logic                         in_vld;
  logic [CH_W-1:0]              in_ch;
  logic [NUM_CH*DATA_WIDTH-1:0] live_data;
  logic [NUM_CH*DATA_WIDTH-1:0] frame_data;
  logic                         frame_vld;
  logic                         frame_rdy;
  logic                         err_seq;
  logic                         err_ch;
  logic [CNT_W-1:0]             ovf_cnt;

  modport master (
    output in_data, in_vld, in_ch, frame_rdy,
    input  live_data, frame_data, frame_vld,
    input  err_seq, err_ch, ovf_cnt
  );

  modport slave (
    input  in_data, in_vld, in_ch, frame_rdy,
    output live_data, frame_data, frame_vld,
    output err_seq, err_ch, ovf_cnt
  );
endinterface

// File: rtl/i2s_frame_packer.sv
// Collects one sample per channel into a frame, keeps latest
// sample per channel, and buffers one frame on valid/ready.
module i2s_frame_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 2,
  parameter int CH_W       = 1,
  parameter int CNT_W      = 8
) (
  input  logic              sck,
  input  logic              rst_n,
  input  logic              clr,
  i2s_frame_packer_if.slave bus
);
  localparam int W = NUM_CH * DATA_WIDTH;
  localparam logic [CH_W:0] NCH =
    (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0] LAST =
    CH_W'(NUM_CH - 1);

  logic [W-1:0]      live_q;
  logic [W-1:0]      cap_q;
  logic [W-1:0]      frame_q;
  logic [W-1:0]      live_nxt;
  logic [W-1:0]      cap_nxt;
  logic [NUM_CH-1:0] seen_q;
  logic [NUM_CH-1:0] hot;
  logic              frame_vld_q;
  logic              err_seq_q;
  logic              err_ch_q;
  logic [CNT_W-1:0]  ovf_q;
  logic              ch_ok;
  logic              ch_bad;
  logic              last;
  logic              dup;
  logic              complete;
  logic              buf_free;

  assign ch_ok    = bus.in_vld &&
                    ({1'b0, bus.in_ch} < NCH);
  assign ch_bad   = bus.in_vld && !ch_ok;
  assign last     = ch_ok && (bus.in_ch == LAST);
  assign dup      = |(seen_q & hot);
  assign complete = last && (&(seen_q | hot));
  assign buf_free = !frame_vld_q || bus.frame_rdy;

  // One-hot of the addressed slot, empty for invalid samples
  always_comb begin
    hot = '0;
    for (int k = 0; k < NUM_CH; k++)
      hot[k] = ch_ok && (bus.in_ch == CH_W'(k));
  end

  // Merge the incoming sample into live and capture slots
  always_comb begin
    live_nxt = live_q;
    cap_nxt  = cap_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (hot[k]) begin
        live_nxt[k*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
        cap_nxt[k*DATA_WIDTH +: DATA_WIDTH]  = bus.in_data;
      end
    end
  end

  // Frame assembly, output buffer and sticky status
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      live_q      <= '0;
      cap_q       <= '0;
      frame_q     <= '0;
      seen_q      <= '0;
      frame_vld_q <= 1'b0;
      err_seq_q   <= 1'b0;
      err_ch_q    <= 1'b0;
      ovf_q       <= '0;
    end else if (clr) begin
      seen_q      <= '0;
      frame_vld_q <= 1'b0;
      err_seq_q   <= 1'b0;
      err_ch_q    <= 1'b0;
      ovf_q       <= '0;
    end else begin
      if (frame_vld_q && bus.frame_rdy)
        frame_vld_q <= 1'b0;
      if (ch_bad)
        err_ch_q <= 1'b1;
      if (ch_ok) begin
        live_q <= live_nxt;
        cap_q  <= cap_nxt;
        if (dup)
          err_seq_q <= 1'b1;
        if (last) begin
          seen_q <= '0;
          if (!complete) begin
            err_seq_q <= 1'b1;
          end else if (buf_free) begin
            frame_q     <= cap_nxt;
            frame_vld_q <= 1'b1;
          end else if (ovf_q != '1) begin
            ovf_q <= ovf_q + CNT_W'(1);
          end
        end else begin
          seen_q <= seen_q | hot;
        end
      end
    end
  end

  assign bus.live_data  = live_q;
  assign bus.frame_data = frame_q;
  assign bus.frame_vld  = frame_vld_q;
  assign bus.err_seq    = err_seq_q;
  assign bus.err_ch     = err_ch_q;
  assign bus.ovf_cnt    = ovf_q;
endmodule

// File: tb/tb_i2s_frame_packer.sv
// Scoreboard bench for i2s_frame_packer: random and directed
// traffic on a 2-channel instance, directed on a 3-channel one.
module tb_i2s_frame_packer;
  logic sck   = 1'b0;
  logic rst_n = 1'b0;
  logic clr_a = 1'b0;
  logic clr_b = 1'b0;

  always #5 sck = ~sck;

  i2s_frame_packer_if #(
    .DATA_WIDTH(16), .NUM_CH(2), .CH_W(1), .CNT_W(8)
  ) ba ();
  i2s_frame_packer_if #(
    .DATA_WIDTH(16), .NUM_CH(3), .CH_W(2), .CNT_W(8)
  ) bb ();

  i2s_frame_packer #(
    .DATA_WIDTH(16), .NUM_CH(2), .CH_W(1), .CNT_W(8)
  ) dut_a (
    .sck(sck), .rst_n(rst_n), .clr(clr_a), .bus(ba)
  );
  i2s_frame_packer #(
    .DATA_WIDTH(16), .NUM_CH(3), .CH_W(2), .CNT_W(8)
  ) dut_b (
    .sck(sck), .rst_n(rst_n), .clr(clr_b), .bus(bb)
  );

  int checks = 0;
  int errors = 0;

  // reference model of the 2-channel instance
  logic [15:0] m_live [2];
  logic [15:0] m_cap  [2];
  bit          m_seen [2];
  bit          m_full;
  bit          m_eseq;
  int          m_ovf;
  logic [31:0] sb [$];
  bit          rdy_a;
  bit          nxt;

  task automatic check(string name,
                       logic [63:0] act,
                       logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic model_reset(bit keep_live);
    for (int k = 0; k < 2; k++) begin
      m_seen[k] = 0;
      if (!keep_live) begin
        m_live[k] = '0;
        m_cap[k]  = '0;
      end
    end
    m_full = 0;
    m_eseq = 0;
    m_ovf  = 0;
    sb.delete();
  endtask

  // effect of one cycle of input on the 2-channel model
  task automatic model_a(bit v, bit c,
                         logic [15:0] d, bit r);
    bit acc;
    acc = m_full && r;
    if (v) begin
      m_live[c] = d;
      m_cap[c]  = d;
      if (m_seen[c]) m_eseq = 1;
      m_seen[c] = 1;
      if (c == 1'b1) begin
        if (m_seen[0] && m_seen[1]) begin
          if (!m_full || r) begin
            sb.push_back({m_cap[1], m_cap[0]});
            m_full = 1;
            acc    = 0;
          end else if (m_ovf < 255) begin
            m_ovf++;
          end
        end else begin
          m_eseq = 1;
        end
        m_seen[0] = 0;
        m_seen[1] = 0;
      end
    end
    if (acc) m_full = 0;
  endtask

  task automatic step_a(bit v, bit c,
                        logic [15:0] d, bit r);
    @(posedge sck);
    #1;
    ba.in_vld    = v;
    ba.in_ch     = c;
    ba.in_data   = d;
    ba.frame_rdy = r;
    rdy_a        = r;
    model_a(v, c, d, r);
  endtask

  task automatic frame_a(logic [15:0] d0,
                         logic [15:0] d1, bit r);
    step_a(1, 0, d0, r);
    step_a(1, 1, d1, r);
  endtask

  task automatic clr_dut_a();
    @(posedge sck);
    #1;
    clr_a        = 1'b1;
    ba.in_vld    = 1'b0;
    ba.frame_rdy = 1'b0;
    rdy_a        = 0;
    model_reset(1);
    @(posedge sck);
    #1;
    clr_a = 1'b0;
  endtask

  // compare status of instance A against the model
  task automatic chk_a(string tag);
    bit ev;
    ev = m_full;
    step_a(0, 0, '0, rdy_a);
    @(negedge sck);
    check({tag, "_vld"}, ba.frame_vld, ev);
    check({tag, "_eseq"}, ba.err_seq, m_eseq);
    check({tag, "_ech"}, ba.err_ch, 0);
    check({tag, "_ovf"}, ba.ovf_cnt, m_ovf);
    check({tag, "_live"}, ba.live_data,
          {m_live[1], m_live[0]});
  endtask

  task automatic step_b(bit v, logic [1:0] c,
                        logic [15:0] d);
    @(posedge sck);
    #1;
    bb.in_vld  = v;
    bb.in_ch   = c;
    bb.in_data = d;
  endtask

  // monitor: every presented frame must match the queue head
  always @(negedge sck) begin
    if (rst_n && !clr_a && ba.frame_vld) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got frame %h expected none",
                 ba.frame_data);
      end else begin
        check("frame_data", ba.frame_data, sb[0]);
        if (ba.frame_rdy) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ba.in_vld = 0; ba.in_ch = 0; ba.in_data = 0;
    ba.frame_rdy = 0;
    bb.in_vld = 0; bb.in_ch = 0; bb.in_data = 0;
    bb.frame_rdy = 1;
    rdy_a = 0;
    nxt   = 0;
    model_reset(0);

    @(negedge sck);
    check("rst_vld", ba.frame_vld, 0);
    check("rst_data", ba.frame_data, 0);
    check("rst_live", ba.live_data, 0);
    check("rst_eseq", ba.err_seq, 0);
    check("rst_ech", ba.err_ch, 0);
    check("rst_ovf", ba.ovf_cnt, 0);
    @(posedge sck);
    #1;
    rst_n = 1'b1;

    // 3-channel instance
    step_b(1, 0, 16'h1111);
    step_b(1, 1, 16'h2222);
    step_b(1, 2, 16'h3333);
    step_b(0, 0, 16'h0);
    @(negedge sck);
    check("b_vld", bb.frame_vld, 1);
    check("b_frame", bb.frame_data, 48'h333322221111);
    check("b_eseq0", bb.err_seq, 0);
    step_b(1, 3, 16'hFFFF);
    step_b(0, 0, 16'h0);
    @(negedge sck);
    check("b_ech", bb.err_ch, 1);
    check("b_live_keep", bb.live_data, 48'h333322221111);
    check("b_eseq1", bb.err_seq, 0);
    @(posedge sck);
    #1;
    clr_b = 1'b1;
    bb.in_vld = 1; bb.in_ch = 0; bb.in_data = 16'h5555;
    @(posedge sck);
    #1;
    clr_b = 1'b0;
    bb.in_vld = 0;
    @(negedge sck);
    check("b_clr_ech", bb.err_ch, 0);
    check("b_clr_eseq", bb.err_seq, 0);
    check("b_clr_ovf", bb.ovf_cnt, 0);
    check("b_clr_vld", bb.frame_vld, 0);
    check("b_clr_live", bb.live_data, 48'h333322221111);
    check("b_clr_data", bb.frame_data, 48'h333322221111);
    step_b(1, 1, 16'hAAAA);
    step_b(1, 2, 16'hBBBB);
    step_b(0, 0, 16'h0);
    @(negedge sck);
    check("b_seen_vld", bb.frame_vld, 0);
    check("b_seen_eseq", bb.err_seq, 1);

    // basic frame and latency
    clr_dut_a();
    step_a(1, 0, 16'h1234, 1);
    step_a(1, 1, 16'hABCD, 1);
    @(negedge sck);
    check("lat_early", ba.frame_vld, 0);
    step_a(0, 0, '0, 1);
    @(negedge sck);
    check("basic_vld", ba.frame_vld, 1);
    check("basic_data", ba.frame_data, 32'hABCD1234);
    check("basic_eseq", ba.err_seq, 0);
    check("basic_ech", ba.err_ch, 0);

    // missing channel
    clr_dut_a();
    step_a(1, 1, 16'h7777, 1);
    step_a(0, 0, '0, 1);
    step_a(0, 0, '0, 1);
    @(negedge sck);
    check("miss_vld", ba.frame_vld, 0);
    check("miss_eseq", ba.err_seq, 1);

    // duplicate channel
    clr_dut_a();
    step_a(1, 0, 16'h0001, 1);
    step_a(1, 0, 16'h0002, 1);
    step_a(1, 1, 16'h0003, 1);
    step_a(0, 0, '0, 1);
    @(negedge sck);
    check("dup_vld", ba.frame_vld, 1);
    check("dup_data", ba.frame_data, 32'h00030002);
    check("dup_eseq", ba.err_seq, 1);

    // backpressure and saturation
    clr_dut_a();
    frame_a(16'h00A0, 16'h00A1, 0);
    frame_a(16'h00B0, 16'h00B1, 0);
    step_a(0, 0, '0, 0);
    @(negedge sck);
    check("bp_data", ba.frame_data, 32'h00A100A0);
    check("bp_ovf1", ba.ovf_cnt, 1);
    for (int i = 0; i < 300; i++)
      frame_a(16'($urandom), 16'($urandom), 0);
    step_a(0, 0, '0, 0);
    @(negedge sck);
    check("bp_sat", ba.ovf_cnt, 255);
    check("bp_hold", ba.frame_data, 32'h00A100A0);
    chk_a("bp");
    for (int i = 0; i < 3; i++)
      step_a(0, 0, '0, 1);
    @(negedge sck);
    check("bp_drain", sb.size(), 0);

    // commit coinciding with accept
    clr_dut_a();
    frame_a(16'h00C0, 16'h00C1, 0);
    step_a(1, 0, 16'h00D0, 0);
    step_a(1, 1, 16'h00D1, 1);
    step_a(0, 0, '0, 0);
    @(negedge sck);
    check("b2b_vld", ba.frame_vld, 1);
    check("b2b_data", ba.frame_data, 32'h00D100D0);
    step_a(0, 0, '0, 1);
    step_a(0, 0, '0, 1);

    // async reset mid-frame
    clr_dut_a();
    step_a(1, 0, 16'h5A5A, 1);
    #2;
    rst_n = 1'b0;
    ba.in_vld = 0;
    #1;
    check("arst_vld", ba.frame_vld, 0);
    check("arst_data", ba.frame_data, 0);
    check("arst_live", ba.live_data, 0);
    check("arst_ovf", ba.ovf_cnt, 0);
    model_reset(0);
    @(posedge sck);
    #1;
    rst_n = 1'b1;
    step_a(1, 1, 16'h6B6B, 1);
    step_a(0, 0, '0, 1);
    step_a(0, 0, '0, 1);
    @(negedge sck);
    check("arst_seen_vld", ba.frame_vld, 0);
    check("arst_seen_eseq", ba.err_seq, 1);

    // randomized traffic against the model
    clr_dut_a();
    nxt = 0;
    for (int i = 0; i < 400; i++) begin
      bit v, c, r;
      v = ($urandom % 4) != 0;
      c = (($urandom % 8) == 0) ? 1'($urandom) : nxt;
      r = ($urandom % 10) < 7;
      if (v) nxt = ~c;
      step_a(v, c, 16'($urandom), r);
      if ((i % 50) == 49) chk_a("rnd");
    end
    for (int i = 0; i < 4; i++)
      step_a(0, 0, '0, 1);
    @(negedge sck);
    check("rnd_drain", sb.size(), 0);
    chk_a("rnd_end");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
